// File: rtl/fuzzy_pkg.sv
// Shared types, constants and index helpers for the interval type-2
// fuzzy rule-evaluation datapath.
package fuzzy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic TNORM_MIN  = 1'b0;
    localparam logic TNORM_PROD = 1'b1;

    // Ceiling log2, used only to size ports and counters at elaboration.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) res++;
        return res;
    endfunction

    // LSB position of membership grade 'set_idx' inside a packed grade vector.
    function automatic int grade_lo(input int set_idx, input int data_w);
        return set_idx * data_w;
    endfunction

    // LSB position of the consequent of rule 'rule' inside the packed rule map.
    function automatic int cons_lo(input int rule, input int cons_w);
        return rule * cons_w;
    endfunction

endpackage

// File: rtl/it2_tnorm.sv
// Combinational t-norm: min(a,b) or truncated fixed-point product
// (a*b) >> DATA_W, selected by mode.
module it2_tnorm
    import fuzzy_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              mode,
    output logic [DATA_W-1:0] y
);

    logic [2*DATA_W-1:0] prod;

    // Select the requested t-norm; the product keeps its upper half so 1.0 is
    // represented by 2^DATA_W and full-scale inputs give slightly under 1.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output on
        // every path (here: prod first, y in both branches) so no latch is inferred.
        prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        if (mode == TNORM_PROD) begin
            y = prod[2*DATA_W-1 -: DATA_W];
        end else begin
            y = (a < b) ? a : b;
        end
    end

endmodule

// File: rtl/it2_rule_engine.sv
// Interval type-2 rule evaluation engine: evaluates all N_SETS^2 rules one
// per clock on captured grades, aggregates per-consequent upper/lower firing
// strengths by max and publishes them atomically with a done pulse.
module it2_rule_engine
    import fuzzy_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int N_SETS = 3,
    parameter  int N_OUT  = 3,
    localparam int N_R    = N_SETS * N_SETS,
    localparam int CONS_W = clog2(N_OUT + 1),
    localparam int RI_W   = (clog2(N_R) > 0) ? clog2(N_R) : 1,
    localparam int FC_W   = clog2(N_R + 1)
) (
    input  logic                     clk_0,
    input  logic                     Srst,
    input  logic                     start,
    input  logic                     tnorm_prod,
    input  logic [N_SETS*DATA_W-1:0] mu1_up,
    input  logic [N_SETS*DATA_W-1:0] mu1_low,
    input  logic [N_SETS*DATA_W-1:0] mu2_up,
    input  logic [N_SETS*DATA_W-1:0] mu2_low,
    input  logic [N_R*CONS_W-1:0]    rule_map,
    output logic                     busy,
    output logic                     done,
    output logic [N_OUT*DATA_W-1:0]  out_up,
    output logic [N_OUT*DATA_W-1:0]  out_low,
    output logic [RI_W-1:0]          rule_idx,
    output logic [FC_W-1:0]          fired_cnt,
    output logic                     fou_err
);

    localparam int SET_W = (clog2(N_SETS) > 0) ? clog2(N_SETS) : 1;

    state_t state, state_nxt;
    logic   load, step, last_rule;

    // Captured operands: the input ports are free to change once a run starts.
    logic [DATA_W-1:0] m1_up_q  [N_SETS];
    logic [DATA_W-1:0] m1_low_q [N_SETS];
    logic [DATA_W-1:0] m2_up_q  [N_SETS];
    logic [DATA_W-1:0] m2_low_q [N_SETS];
    logic [CONS_W-1:0] cons_q   [N_R];
    logic              tnorm_q;

    logic [SET_W-1:0]  i_idx, j_idx;
    logic [DATA_W-1:0] acc_up      [N_OUT];
    logic [DATA_W-1:0] acc_low     [N_OUT];
    logic [DATA_W-1:0] acc_up_nxt  [N_OUT];
    logic [DATA_W-1:0] acc_low_nxt [N_OUT];
    logic [DATA_W-1:0] res_up      [N_OUT];
    logic [DATA_W-1:0] res_low     [N_OUT];

    logic [DATA_W-1:0] f_up, f_low;
    logic [CONS_W-1:0] cur_cons;
    logic              rule_active;
    logic              fou_viol;

    function automatic logic [DATA_W-1:0] clamp_low(input logic [DATA_W-1:0] lo,
                                                    input logic [DATA_W-1:0] up);
        return (lo > up) ? up : lo;
    endfunction

    // State register.
    always_ff @(posedge clk_0) begin
        // NOTE: clocked state uses non-blocking '<=' so every register samples
        // pre-edge values regardless of block ordering.
        if (Srst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic and handshake decode; start is honoured only in IDLE/DONE.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        last_rule = (rule_idx == RI_W'(N_R - 1));
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = EVAL;
                end
            end
            EVAL: begin
                busy = 1'b1;
                step = 1'b1;
                if (last_rule) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                load      = start;
                state_nxt = start ? EVAL : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Footprint-of-uncertainty check on the grades about to be captured.
    always_comb begin
        fou_viol = 1'b0;
        for (int s = 0; s < N_SETS; s++) begin
            if (mu1_low[grade_lo(s, DATA_W) +: DATA_W] > mu1_up[grade_lo(s, DATA_W) +: DATA_W])
                fou_viol = 1'b1;
            if (mu2_low[grade_lo(s, DATA_W) +: DATA_W] > mu2_up[grade_lo(s, DATA_W) +: DATA_W])
                fou_viol = 1'b1;
        end
    end

    // Operand capture at an accepted start; lower grades are stored pre-clamped.
    always_ff @(posedge clk_0) begin
        // NOTE: operand storage has no reset; it is always written by a start
        // before the evaluation that reads it, so reset adds nothing but cost.
        if (load) begin
            tnorm_q <= tnorm_prod;
            for (int s = 0; s < N_SETS; s++) begin
                m1_up_q[s]  <= mu1_up[grade_lo(s, DATA_W) +: DATA_W];
                m2_up_q[s]  <= mu2_up[grade_lo(s, DATA_W) +: DATA_W];
                m1_low_q[s] <= clamp_low(mu1_low[grade_lo(s, DATA_W) +: DATA_W],
                                         mu1_up[grade_lo(s, DATA_W) +: DATA_W]);
                m2_low_q[s] <= clamp_low(mu2_low[grade_lo(s, DATA_W) +: DATA_W],
                                         mu2_up[grade_lo(s, DATA_W) +: DATA_W]);
            end
            for (int r = 0; r < N_R; r++) begin
                cons_q[r] <= rule_map[cons_lo(r, CONS_W) +: CONS_W];
            end
        end
    end

    it2_tnorm #(.DATA_W(DATA_W)) u_tnorm_up (
        .a    (m1_up_q[i_idx]),
        .b    (m2_up_q[j_idx]),
        .mode (tnorm_q),
        .y    (f_up)
    );

    it2_tnorm #(.DATA_W(DATA_W)) u_tnorm_low (
        .a    (m1_low_q[i_idx]),
        .b    (m2_low_q[j_idx]),
        .mode (tnorm_q),
        .y    (f_low)
    );

    // Current rule's activity and the max-aggregated accumulator candidates.
    always_comb begin
        cur_cons    = cons_q[rule_idx];
        rule_active = (m1_up_q[i_idx] != '0) && (m2_up_q[j_idx] != '0) &&
                      (cur_cons < CONS_W'(N_OUT));
        for (int k = 0; k < N_OUT; k++) begin
            acc_up_nxt[k]  = acc_up[k];
            acc_low_nxt[k] = acc_low[k];
            if (rule_active && (cur_cons == CONS_W'(k))) begin
                if (f_up  > acc_up[k])  acc_up_nxt[k]  = f_up;
                if (f_low > acc_low[k]) acc_low_nxt[k] = f_low;
            end
        end
    end

    // Rule sequencing, accumulation and atomic publication on the final rule.
    always_ff @(posedge clk_0) begin
        if (Srst) begin
            for (int k = 0; k < N_OUT; k++) begin
                acc_up[k]  <= '0;
                acc_low[k] <= '0;
                res_up[k]  <= '0;
                res_low[k] <= '0;
            end
            rule_idx  <= '0;
            i_idx     <= '0;
            j_idx     <= '0;
            fired_cnt <= '0;
            fou_err   <= 1'b0;
        end else if (load) begin
            for (int k = 0; k < N_OUT; k++) begin
                acc_up[k]  <= '0;
                acc_low[k] <= '0;
            end
            rule_idx  <= '0;
            i_idx     <= '0;
            j_idx     <= '0;
            fired_cnt <= '0;
            fou_err   <= fou_viol;
        end else if (step) begin
            acc_up  <= acc_up_nxt;
            acc_low <= acc_low_nxt;
            if (rule_active) fired_cnt <= fired_cnt + FC_W'(1);
            if (last_rule) begin
                res_up  <= acc_up_nxt;
                res_low <= acc_low_nxt;
            end else begin
                rule_idx <= rule_idx + RI_W'(1);
                if (j_idx == SET_W'(N_SETS - 1)) begin
                    j_idx <= '0;
                    i_idx <= i_idx + SET_W'(1);
                end else begin
                    j_idx <= j_idx + SET_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_pack
        assign out_up[g*DATA_W +: DATA_W]  = res_up[g];
        assign out_low[g*DATA_W +: DATA_W] = res_low[g];
    end

endmodule
